uart_cmd_master: RTL

UART_CMD_MASTER -- requirements
Module: uart_cmd_master

---
 rtl/uart_cmd_master_pkg.sv | 22 ++
 rtl/uart_bit_ser.sv | 57 +++++
 rtl/uart_cmd_master.sv | 121 ++++++++++++
 3 files changed

// File: rtl/uart_cmd_master_pkg.sv
// Shared constants and types for the UART command master: sequencer states,
// command byte, frame count and a counter-width helper.
package uart_cmd_master_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SEND     = 3'd1,
    ST_GAP      = 3'd2,
    ST_WAIT_RSP = 3'd3,
    ST_DONE     = 3'd4
  } state_t;

  localparam logic [7:0] CMD_BYTE    = 8'h73;
  localparam int         FRAME_COUNT = 4;
  localparam int         RSP_BYTES   = 3;

  // Bits needed to hold values 0..n-1, never less than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_bit_ser.sv
// 8N1 serializer: go loads a byte and starts the start bit on the next cycle;
// frame_done is high during the last cycle of the stop bit.
module uart_bit_ser
  import uart_cmd_master_pkg::*;
#(
  parameter int BIT_CYC = 5208
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       go,
  input  logic [7:0] data,
  output logic       tx,
  output logic       frame_done
);

  localparam int CW = cnt_width(BIT_CYC);

  logic [CW-1:0] baud_cnt;
  logic [3:0]    bit_idx;
  logic [8:0]    shreg;
  logic          active;
  logic          bit_end;

  assign bit_end    = active && (baud_cnt == CW'(BIT_CYC - 1));
  assign frame_done = bit_end && (bit_idx == 4'd9);

  always_ff @(posedge clk) begin
    if (!rst) begin
      tx       <= 1'b1;
      active   <= 1'b0;
      baud_cnt <= '0;
      bit_idx  <= 4'd0;
      shreg    <= 9'h0;
    end else if (go) begin
      tx       <= 1'b0;
      active   <= 1'b1;
      baud_cnt <= '0;
      bit_idx  <= 4'd0;
      shreg    <= {1'b1, data};
    end else if (bit_end) begin
      baud_cnt <= '0;
      if (bit_idx == 4'd9) begin
        active  <= 1'b0;
        bit_idx <= 4'd0;
        tx      <= 1'b1;
      end else begin
        // shreg holds d0..d7 then the stop bit; shifting in ones keeps the line idle-safe
        bit_idx <= bit_idx + 4'd1;
        tx      <= shreg[0];
        shreg   <= {1'b1, shreg[8:1]};
      end
    end else if (active) begin
      baud_cnt <= baud_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_cmd_master.sv
// Sends 0x73, op_a, 0x73, op_b over UART, then collects a 3-byte response
// (MSB first) into result, with a response timeout that sets err.
module uart_cmd_master
  import uart_cmd_master_pkg::*;
#(
  parameter int CLK_FREQ    = 50_000_000,
  parameter int BAUD        = 9600,
  parameter int GAP_BITS    = 10,
  parameter int RSP_TIMEOUT = 50_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  op_a,
  input  logic [7:0]  op_b,
  output logic        tx,
  input  logic        rx_ready,
  input  logic [7:0]  rx_data,
  output logic        busy,
  output logic [23:0] result,
  output logic        done,
  output logic        err
);

  localparam int BIT_CYC = CLK_FREQ / BAUD;
  localparam int GAP_CYC = GAP_BITS * BIT_CYC;
  localparam int GW      = cnt_width(GAP_CYC);
  localparam int TW      = cnt_width(RSP_TIMEOUT);

  state_t        state, state_nxt;
  logic [1:0]    byte_idx;
  logic [1:0]    nxt_idx;
  logic [GW-1:0] gap_cnt;
  logic [TW-1:0] tmo_cnt;
  logic [1:0]    rsp_cnt;
  logic [7:0]    rsp_hi, rsp_mid;
  logic [7:0]    op_a_q, op_b_q;

  logic       accept, gap_end, last_frame, rsp_last, tmo_hit;
  logic       go, frame_done;
  logic [7:0] ser_data;

  assign accept     = (state == ST_IDLE) && start;
  assign gap_end    = (state == ST_GAP) && (gap_cnt == GW'(GAP_CYC - 1));
  assign last_frame = (byte_idx == 2'(FRAME_COUNT - 1));
  assign rsp_last   = (state == ST_WAIT_RSP) && rx_ready && (rsp_cnt == 2'(RSP_BYTES - 1));
  assign tmo_hit    = (state == ST_WAIT_RSP) && (tmo_cnt == TW'(RSP_TIMEOUT - 1));
  assign nxt_idx    = byte_idx + 2'd1;

  // Next frame is launched on the final gap cycle so its start bit follows the gap directly.
  assign go       = accept || (gap_end && !last_frame);
  assign ser_data = accept      ? CMD_BYTE :
                    !nxt_idx[0] ? CMD_BYTE :
                    nxt_idx[1]  ? op_b_q : op_a_q;

  assign busy = (state != ST_IDLE);
  assign done = (state == ST_DONE);

  uart_bit_ser #(
    .BIT_CYC (BIT_CYC)
  ) u_ser (
    .clk        (clk),
    .rst        (rst),
    .go         (go),
    .data       (ser_data),
    .tx         (tx),
    .frame_done (frame_done)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:     if (start) state_nxt = ST_SEND;
      ST_SEND:     if (frame_done) state_nxt = ST_GAP;
      ST_GAP:      if (gap_end) state_nxt = last_frame ? ST_WAIT_RSP : ST_SEND;
      ST_WAIT_RSP: if (rsp_last || tmo_hit) state_nxt = ST_DONE;
      ST_DONE:     state_nxt = ST_IDLE;
      default:     state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= ST_IDLE;
      byte_idx <= 2'd0;
      gap_cnt  <= '0;
      tmo_cnt  <= '0;
      rsp_cnt  <= 2'd0;
      rsp_hi   <= 8'h0;
      rsp_mid  <= 8'h0;
      op_a_q   <= 8'h0;
      op_b_q   <= 8'h0;
      result   <= 24'h0;
      err      <= 1'b0;
    end else begin
      state   <= state_nxt;
      gap_cnt <= (state == ST_GAP && !gap_end) ? gap_cnt + 1'b1 : '0;
      tmo_cnt <= (state == ST_WAIT_RSP && !tmo_hit) ? tmo_cnt + 1'b1 : '0;

      if (accept) begin
        op_a_q   <= op_a;
        op_b_q   <= op_b;
        err      <= 1'b0;
        byte_idx <= 2'd0;
      end
      if (gap_end && !last_frame) byte_idx <= nxt_idx;

      if (state == ST_WAIT_RSP && rx_ready) begin
        rsp_cnt <= rsp_cnt + 2'd1;
        if (rsp_cnt == 2'd0) rsp_hi  <= rx_data;
        if (rsp_cnt == 2'd1) rsp_mid <= rx_data;
      end
      if (state != ST_WAIT_RSP) rsp_cnt <= 2'd0;

      // A third byte arriving on the expiry cycle wins over the timeout.
      if (rsp_last)     result <= {rsp_hi, rsp_mid, rx_data};
      else if (tmo_hit) err    <= 1'b1;
    end
  end

endmodule
